// File: rtl/btpipe_out_ctrl.sv
// Block-throttled pipe-out controller: buffers producer words in a circular RAM
// and releases them to the host endpoint one BLOCK_WORDS block at a time.
module btpipe_out_ctrl #(
    parameter int BLOCK_WORDS = 256,
    parameter int ADDR_W      = 10
) (
    input  logic              ti_clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [15:0]       src_data,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic              ep_read,
    input  logic              ep_blockstrobe,
    output logic              ep_ready,
    output logic [15:0]       ep_datain,
    output logic [ADDR_W:0]   fill_level,
    output logic [15:0]       block_count,
    output logic              underrun
);
    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   BLOCK_LVL = (ADDR_W + 1)'(BLOCK_WORDS);
    localparam logic [ADDR_W:0]   FILL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   FILL_ZERO = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    state_t              state_r;
    logic [15:0]         mem_r [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_r;
    logic [ADDR_W-1:0]   rd_ptr_r;
    logic [ADDR_W-1:0]   word_cnt_r;
    logic [ADDR_W:0]     fill_r;
    logic                ep_ready_r;
    logic                underrun_r;
    logic [15:0]         ep_datain_r;
    logic [15:0]         block_count_r;

    logic                src_ready_s;
    logic                push_s;
    logic                read_s;
    logic                pop_s;
    logic                last_s;
    logic [ADDR_W:0]     fill_next_s;

    // Handshake decode; the MSB of fill_r is set only when the buffer is full.
    always_comb begin
        src_ready_s = reset_n & enable & ~fill_r[ADDR_W];
        push_s      = src_valid & src_ready_s;
        read_s      = (state_r == ST_XFER) & ep_read;
        pop_s       = read_s & (fill_r != FILL_ZERO);
        last_s      = read_s & (word_cnt_r == LAST_WORD);
        case ({push_s, pop_s})
            2'b10:   fill_next_s = fill_r + FILL_ONE;
            2'b01:   fill_next_s = fill_r - FILL_ONE;
            default: fill_next_s = fill_r;
        endcase
    end

    // Buffer RAM write port, left unreset so it can map onto block RAM.
    always_ff @(posedge ti_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= src_data;
        end
    end

    // Block FSM, pointers, fill level and all registered outputs.
    always_ff @(posedge ti_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            word_cnt_r    <= PTR_ZERO;
            fill_r        <= FILL_ZERO;
            ep_ready_r    <= 1'b0;
            underrun_r    <= 1'b0;
            ep_datain_r   <= 16'h0000;
            block_count_r <= 16'h0000;
        end else if (!enable) begin
            // Flush: block_count and ep_datain deliberately survive.
            state_r    <= ST_IDLE;
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            word_cnt_r <= PTR_ZERO;
            fill_r     <= FILL_ZERO;
            ep_ready_r <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            fill_r <= fill_next_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (read_s) begin
                ep_datain_r <= pop_s ? mem_r[rd_ptr_r] : 16'h0000;
                if (!pop_s) begin
                    underrun_r <= 1'b1;
                end
            end
            case (state_r)
                ST_IDLE: begin
                    if (fill_r >= BLOCK_LVL) begin
                        state_r    <= ST_ARMED;
                        ep_ready_r <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (ep_blockstrobe) begin
                        state_r    <= ST_XFER;
                        ep_ready_r <= 1'b0;
                        word_cnt_r <= PTR_ZERO;
                    end
                end
                ST_XFER: begin
                    if (last_s) begin
                        state_r       <= ST_IDLE;
                        word_cnt_r    <= PTR_ZERO;
                        block_count_r <= block_count_r + 16'd1;
                    end else if (read_s) begin
                        word_cnt_r <= word_cnt_r + PTR_ONE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    ep_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign src_ready   = src_ready_s;
    assign ep_ready    = ep_ready_r;
    assign ep_datain   = ep_datain_r;
    assign fill_level  = fill_r;
    assign block_count = block_count_r;
    assign underrun    = underrun_r;

endmodule

// File: tb/tb_btpipe_out_ctrl.sv
// Randomized bench for btpipe_out_ctrl against a queue-based reference model.
module tb_btpipe_out_ctrl;
    localparam int BW    = 256;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          ti_clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [15:0]   src_data;
    logic          src_valid;
    logic          src_ready;
    logic          ep_read;
    logic          ep_blockstrobe;
    logic          ep_ready;
    logic [15:0]   ep_datain;
    logic [AW:0]   fill_level;
    logic [15:0]   block_count;
    logic          underrun;

    btpipe_out_ctrl #(.BLOCK_WORDS(BW), .ADDR_W(AW)) dut (
        .ti_clk         (ti_clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .ep_read        (ep_read),
        .ep_blockstrobe (ep_blockstrobe),
        .ep_ready       (ep_ready),
        .ep_datain      (ep_datain),
        .fill_level     (fill_level),
        .block_count    (block_count),
        .underrun       (underrun)
    );

    always #5 ti_clk = ~ti_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: words waiting in order, block phase (0 idle, 1 armed, 2 transfer).
    logic [15:0] mq[$];
    int          m_mode;
    int          m_cnt;
    int          m_blocks;
    logic        m_ur;
    logic        m_rdy;
    logic [15:0] m_data;
    logic [15:0] next_word;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode   = 0;
        m_cnt    = 0;
        m_blocks = 0;
        m_ur     = 1'b0;
        m_rdy    = 1'b0;
        m_data   = 16'h0000;
    endtask

    // One clock: apply inputs, predict, clock, then compare every output.
    task automatic step(input logic en, input logic v, input logic [15:0] d,
                        input logic rd, input logic sb);
        int   sz;
        logic push;
        enable = en; src_valid = v; src_data = d; ep_read = rd; ep_blockstrobe = sb;
        #1;
        sz   = mq.size();
        push = v && en && (sz < DEPTH);
        check_val("src_ready", 32'(src_ready), 32'(en && (sz < DEPTH)));
        if (!en) begin
            mq.delete();
            m_mode = 0;
            m_cnt  = 0;
            m_ur   = 1'b0;
        end else begin
            if (m_mode == 2) begin
                if (rd) begin
                    if (sz > 0) m_data = mq.pop_front();
                    else begin
                        m_data = 16'h0000;
                        m_ur   = 1'b1;
                    end
                    m_cnt++;
                    if (m_cnt == BW) begin
                        m_mode   = 0;
                        m_cnt    = 0;
                        m_blocks = (m_blocks + 1) % 65536;
                    end
                end
            end else if (m_mode == 1) begin
                if (sb) m_mode = 2;
            end else if (sz >= BW) begin
                m_mode = 1;
            end
            if (push) mq.push_back(d);
        end
        m_rdy = (m_mode == 1);
        @(posedge ti_clk);
        #1;
        check_val("ep_ready",    32'(ep_ready),    32'(m_rdy));
        check_val("ep_datain",   32'(ep_datain),   32'(m_data));
        check_val("fill_level",  32'(fill_level),  32'(mq.size()));
        check_val("block_count", 32'(block_count), 32'(m_blocks));
        check_val("underrun",    32'(underrun),    32'(m_ur));
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1, next_word, 1'b0, 1'b0);
            next_word = next_word + 16'd1;
        end
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    endtask

    task automatic idle_n(input logic en, input int n);
        for (int i = 0; i < n; i++) step(en, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        int ready_low;
        reset_n = 1'b0; enable = 1'b1; src_valid = 1'b0; src_data = 16'h0000;
        ep_read = 1'b0; ep_blockstrobe = 1'b0;
        next_word = 16'h0000;
        model_reset();
        #2;
        check_val("rst_src_ready",   32'(src_ready),   32'(0));
        check_val("rst_ep_ready",    32'(ep_ready),    32'(0));
        check_val("rst_ep_datain",   32'(ep_datain),   32'(0));
        check_val("rst_fill",        32'(fill_level),  32'(0));
        check_val("rst_block_count", 32'(block_count), 32'(0));
        check_val("rst_underrun",    32'(underrun),    32'(0));
        @(negedge ti_clk);
        reset_n = 1'b1;

        // Fill: 255 words do not arm, the 256th arms within two cycles.
        push_n(255);
        check_val("fill255_ready", 32'(ep_ready), 32'(0));
        push_n(1);
        idle_n(1'b1, 1);
        check_val("fill256_ready", 32'(ep_ready), 32'(1));

        // Single block transfer: words 0..255 in order.
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        check_val("strobe_ready_low", 32'(ep_ready), 32'(0));
        read_n(1);
        check_val("blk_first_data", 32'(ep_datain), 32'(0));
        read_n(255);
        check_val("blk_last_data", 32'(ep_datain), 32'(255));
        check_val("blk_count", 32'(block_count), 32'(1));
        check_val("blk_ready", 32'(ep_ready), 32'(0));

        // Back-to-back blocks from 600 buffered words.
        push_n(600);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        read_n(BW);
        check_val("b2b_ready_at_done", 32'(ep_ready), 32'(0));
        idle_n(1'b1, 1);
        check_val("b2b_ready_rearm", 32'(ep_ready), 32'(1));
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        read_n(BW);
        check_val("b2b_fill", 32'(fill_level), 32'(88));
        check_val("b2b_count", 32'(block_count), 32'(3));

        // Continuous push while five blocks drain: pointers wrap.
        target    = m_blocks + 5;
        ready_low = 0;
        for (int i = 0; i < 4000 && m_blocks != target; i++) begin
            step(1'b1, 1'b1, next_word, 1'(m_mode == 2), 1'(m_mode == 1));
            next_word = next_word + 16'd1;
            if (src_ready !== 1'b1) ready_low++;
        end
        check_val("wrap_blocks", 32'(block_count), 32'(target));
        check_val("wrap_ready_low", 32'(ready_low), 32'(0));
        check_val("wrap_underrun", 32'(underrun), 32'(0));

        // Random traffic including occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            logic en_r;
            en_r = ($urandom_range(0, 199) != 0);
            step(en_r, 1'($urandom_range(0, 3) != 0), 16'($urandom),
                 (m_mode == 2) ? 1'($urandom_range(0, 4) != 0) : 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 2) == 0));
        end

        // Underrun: fake an empty buffer during a transfer.
        idle_n(1'b0, 1);
        push_n(BW);
        idle_n(1'b1, 1);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        read_n(10);
        enable = 1'b1; src_valid = 1'b0; ep_read = 1'b1; ep_blockstrobe = 1'b0;
        force dut.fill_r = 11'd0;
        @(posedge ti_clk);
        #1;
        check_val("ur_datain", 32'(ep_datain), 32'(0));
        check_val("ur_flag", 32'(underrun), 32'(1));
        release dut.fill_r;
        m_data = 16'h0000;
        m_ur   = 1'b1;
        idle_n(1'b0, 1);
        check_val("ur_clear", 32'(underrun), 32'(0));
        check_val("ur_fill_clear", 32'(fill_level), 32'(0));

        // Reset in the middle of a transfer.
        push_n(BW);
        idle_n(1'b1, 1);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        read_n(100);
        enable = 1'b1; ep_read = 1'b1;
        reset_n = 1'b0;
        #1;
        check_val("mid_rst_src_ready",   32'(src_ready),   32'(0));
        check_val("mid_rst_ep_ready",    32'(ep_ready),    32'(0));
        check_val("mid_rst_datain",      32'(ep_datain),   32'(0));
        check_val("mid_rst_fill",        32'(fill_level),  32'(0));
        check_val("mid_rst_block_count", 32'(block_count), 32'(0));
        check_val("mid_rst_underrun",    32'(underrun),    32'(0));
        model_reset();
        @(negedge ti_clk);
        reset_n = 1'b1;
        idle_n(1'b1, 3);
        push_n(BW + 4);
        idle_n(1'b1, 1);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        read_n(BW);
        check_val("post_rst_count", 32'(block_count), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/btpipe_out_ctrl.md
BTPIPE_OUT_CTRL -- requirements
Module: btpipe_out_ctrl

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 256: 16-bit words per host block; power of two, 2..512.
REQ-002 SHALL have parameter ADDR_W, default 10: log2 of buffer depth (1024 words); 2^ADDR_W >= 2*BLOCK_WORDS.
REQ-003 SHALL have port ti_clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: host wire-in enable; 0 flushes and holds the block idle.
REQ-006 SHALL have port src_data, input, 16 bits: producer data word.
REQ-007 SHALL have port src_valid, input, 1 bit: src_data valid this cycle.
REQ-008 SHALL have port src_ready, output, 1 bit: buffer can accept a word.
REQ-009 SHALL have port ep_read, input, 1 bit: host pipe requests the next word.
REQ-010 SHALL have port ep_blockstrobe, input, 1 bit: host pipe starts a block transfer.
REQ-011 SHALL have port ep_ready, output, 1 bit: one full block is available.
REQ-012 SHALL have port ep_datain, output, 16 bits: word returned to the pipe.
REQ-013 SHALL have port fill_level, output, ADDR_W+1 bits: words currently buffered.
REQ-014 SHALL have port block_count, output, 16 bits: completed blocks, wraps at 65535 -> 0.
REQ-015 SHALL have port underrun, output, 1 bit: sticky; an ep_read arrived with the buffer empty.

Function
REQ-016 SHALL buffer words in a circular RAM of 2^ADDR_W words, with ADDR_W-bit read and write pointers that wrap modulo depth.
REQ-017 SHALL drive src_ready = enable AND (fill_level < 2^ADDR_W), combinationally.
REQ-018 SHALL write src_data on each cycle where src_valid AND src_ready are both 1; src_valid while src_ready=0 is dropped without changing state.
REQ-019 SHALL implement states IDLE, ARMED and XFER.
REQ-020 SHALL transition IDLE -> ARMED when enable=1 and fill_level >= BLOCK_WORDS; ep_ready SHALL be a register, 1 only in ARMED.
REQ-021 SHALL transition ARMED -> XFER on ep_blockstrobe=1, clearing the word counter; ep_ready SHALL be 0 on the next cycle.
REQ-022 SHALL, in XFER, pop one word per ep_read=1 cycle and register it onto ep_datain on the following clock edge (read latency 1).
REQ-023 SHALL transition XFER -> IDLE on the cycle the BLOCK_WORDS-th ep_read is accepted, and SHALL increment block_count on that same edge.
REQ-024 SHALL hold ep_datain unchanged on cycles without an accepted read.
REQ-025 SHALL treat ep_read outside XFER as a no-op: no pop, no counter change.
REQ-026 SHALL, on ep_read in XFER with fill_level=0, set underrun, drive ep_datain=16'h0000, and still advance the word counter.
REQ-027 SHALL allow a simultaneous push and pop in one cycle, leaving fill_level unchanged.
REQ-028 SHALL allow IDLE -> ARMED on the cycle immediately after XFER -> IDLE if fill_level >= BLOCK_WORDS at that point.
REQ-029 SHALL ignore ep_blockstrobe in IDLE and XFER.
REQ-030 SHALL, when enable=0, go to IDLE, reset both pointers and fill_level to 0, and clear underrun on the next edge; block_count SHALL be retained.

Reset
REQ-031 SHALL, on reset_n=0, asynchronously set: state=IDLE, pointers=0, fill_level=0, block_count=0, underrun=0, ep_ready=0, ep_datain=16'h0000.
REQ-032 SHALL, on reset_n=0, drive src_ready=0 combinationally.
REQ-033 SHALL abandon any partial block on reset mid-XFER, with no block_count increment.
REQ-034 SHALL use reset deassertion synchronous to ti_clk by the instantiating top; the block adds no synchronizer.

Verification
REQ-035 Fill scenario: push 255 words -> ep_ready=0; push word 256 -> ep_ready=1 within 2 cycles.
REQ-036 Block transfer scenario: push 0..255, strobe, then 256 ep_read cycles -> ep_datain sequence 0..255, each 1 cycle after its read; block_count=1; ep_ready=0.
REQ-037 Back-to-back scenario: push 600 words, run two blocks -> second ep_ready rises 1 cycle after first completion; fill_level=88 at the end.
REQ-038 Wrap and concurrency scenario: continuous push during 5 blocks with depth 1024 -> pointers wrap; data ordered; no underrun; src_ready never 0.
REQ-039 Underrun scenario: force ep_read in XFER with fill_level=0 -> ep_datain=0 and underrun=1; enable=0 clears underrun and fill_level.
REQ-040 Reset scenario: assert reset_n mid-XFER after 100 reads -> all outputs at reset values immediately; block_count=0.
